ahb_lite_manager: RTL

- Single-outstanding AHB-Lite manager. It converts a simple valid/ready command interface into AHB-Lite single transfers (NONSEQ only).
- It drives the AHB register subordinate block from firmware-model, test-sequencer or bridge logic.
- It returns read data and error status on a one-cycle response strobe.
- It is the initiating end of the bus that the register subordinate answers.

---
 rtl/ahb_lite_manager_if.sv | 40 ++++
 rtl/ahb_lite_manager.sv | 113 +++++++++++
 2 files changed

// File: rtl/ahb_lite_manager_if.sv
// Command/response handshake plus AHB-Lite manager signals for ahb_lite_manager.
// master is the manager's view; slave is the view of whoever drives commands and the bus responses.
interface ahb_lite_manager_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [AddrWidth-1:0] cmd_addr;
    logic [2:0]           cmd_size;
    logic [DataWidth-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_error;

    logic [AddrWidth-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [DataWidth-1:0] HWDATA;
    logic [DataWidth-1:0] HRDATA;
    logic                 HREADY;
    logic                 HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_manager.sv
// Single-outstanding AHB-Lite manager: turns valid/ready commands into NONSEQ single transfers
// and returns read data / error status on a one-cycle response strobe.
module ahb_lite_manager #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input logic                clk,
    input logic                reset,
    ahb_lite_manager_if.master bus
);
    localparam logic [2:0] MaxSize     = 3'($clog2(DataWidth / 8));
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] haddr_q, haddr_d;
    logic [1:0]           htrans_q, htrans_d;
    logic                 hwrite_q, hwrite_d;
    logic [2:0]           hsize_q, hsize_d;
    logic [DataWidth-1:0] hwdata_q, hwdata_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_error_q, rsp_error_d;

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    // Sizes wider than the data bus never reach the bus.
                    if (bus.cmd_size > MaxSize) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = StAddr;
                        htrans_d = TransNonseq;
                        haddr_d  = bus.cmd_addr;
                        hwrite_d = bus.cmd_write;
                        hsize_d  = bus.cmd_size;
                        wdata_d  = bus.cmd_wdata;
                    end
                end
            end
            StAddr: begin
                if (bus.HREADY) begin
                    state_d  = StData;
                    htrans_d = TransIdle;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                end
            end
            StData: begin
                // A first ERROR cycle arrives with HREADY low, so it simply waits here.
                if (bus.HREADY) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus.HRESP;
                    rsp_rdata_d = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            haddr_q     <= '0;
            htrans_q    <= TransIdle;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle) && !reset;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
endmodule
